// File: rtl/multicycle_fsm_pkg.sv
// ============================================================================
// Module   : multicycle_fsm_pkg
// Brief    : Shared state, opcode, mux-select codes and control decode.
// Revision : 1.0
// ============================================================================
`default_nettype none

package multicycle_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] c_OP_DP  = 2'b00;
    localparam logic [1:0] c_OP_MEM = 2'b01;
    localparam logic [1:0] c_OP_BR  = 2'b10;
    localparam logic [1:0] c_OP_ILL = 2'b11;

    localparam int c_FUNCT_I = 5;
    localparam int c_FUNCT_L = 0;

    localparam logic [1:0] c_SRCB_REG  = 2'b00;
    localparam logic [1:0] c_SRCB_IMM  = 2'b01;
    localparam logic [1:0] c_SRCB_FOUR = 2'b10;

    localparam logic [1:0] c_RES_ALUOUT = 2'b00;
    localparam logic [1:0] c_RES_DATA   = 2'b01;
    localparam logic [1:0] c_RES_ALU    = 2'b10;

    // fetch/decode/retire_rdy are qualifiers combined with live inputs in the top.
    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       alu_src_a;
        logic       alu_op;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       fetch;
        logic       decode;
        logic       retire;
        logic       retire_rdy;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = c_SRCB_FOUR;
                c.result_src = c_RES_ALU;
                c.fetch      = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = c_SRCB_FOUR;
                c.result_src = c_RES_ALU;
                c.decode     = 1'b1;
            end
            S_MEMADR: begin
                c.alu_src_b  = c_SRCB_IMM;
            end
            S_MEMREAD: begin
                c.mem_req    = 1'b1;
                c.adr_src    = 1'b1;
                c.result_src = c_RES_ALUOUT;
            end
            S_MEMWB: begin
                c.result_src = c_RES_DATA;
                c.reg_w      = 1'b1;
                c.retire     = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req    = 1'b1;
                c.adr_src    = 1'b1;
                c.mem_w      = 1'b1;
                c.result_src = c_RES_ALUOUT;
                c.retire_rdy = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_b  = c_SRCB_REG;
                c.alu_op     = 1'b1;
            end
            S_EXECI: begin
                c.alu_src_b  = c_SRCB_IMM;
                c.alu_op     = 1'b1;
            end
            S_ALUWB: begin
                c.result_src = c_RES_ALUOUT;
                c.reg_w      = 1'b1;
                c.retire     = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_b  = c_SRCB_IMM;
                c.result_src = c_RES_ALU;
                c.branch     = 1'b1;
                c.retire     = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/retire_counter.sv
// ============================================================================
// Module   : retire_counter
// Brief    : 32-bit free-running count of retired instructions, wraps to 0.
// Revision : 1.0
// ============================================================================
`default_nettype none

module retire_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/multicycle_fsm.sv
// ============================================================================
// Module   : multicycle_fsm
// Brief    : Multicycle processor control FSM with retirement counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_fsm
    import multicycle_fsm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        IRWrite,
    output logic        NextPC,
    output logic        RegW,
    output logic        MemW,
    output logic        Branch,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic        ALUOp,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [31:0] retire_cnt,
    output logic        retire
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_d;
    ctrl_t  w_ctrl;
    logic   w_retire;
    logic   unused_funct;

    assign unused_funct = ^Funct[4:1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (Op)
                    c_OP_MEM: state_d = S_MEMADR;
                    c_OP_DP:  state_d = Funct[c_FUNCT_I] ? S_EXECI : S_EXECR;
                    c_OP_BR:  state_d = S_BRANCH;
                    default:  state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                state_d = Funct[c_FUNCT_L] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWRITE: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            S_MEMWB:  state_d = S_FETCH;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
        ctrl_d = decode_ctrl(state_d);
    end

    // Control word is registered alongside the state it belongs to, so it
    // always matches state_q; reset loads the FETCH word for the first cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ctrl_q  <= decode_ctrl(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Outputs are held low for as long as reset is asserted.
    always_comb begin
        w_ctrl = '0;
        if (rst_n) begin
            w_ctrl = ctrl_q;
        end
    end

    assign w_retire = w_ctrl.retire
                    | (w_ctrl.retire_rdy & mem_ready)
                    | (w_ctrl.decode & (Op == c_OP_ILL));

    assign mem_req   = w_ctrl.mem_req;
    assign IRWrite   = w_ctrl.fetch & mem_ready;
    assign NextPC    = w_ctrl.fetch & mem_ready;
    assign RegW      = w_ctrl.reg_w;
    assign MemW      = w_ctrl.mem_w;
    assign Branch    = w_ctrl.branch;
    assign AdrSrc    = w_ctrl.adr_src;
    assign ALUSrcA   = w_ctrl.alu_src_a;
    assign ALUOp     = w_ctrl.alu_op;
    assign ALUSrcB   = w_ctrl.alu_src_b;
    assign ResultSrc = w_ctrl.result_src;
    assign retire    = w_retire;

    retire_counter u_retire_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_retire),
        .count (retire_cnt)
    );

endmodule

`default_nettype wire
